// File: rtl/logic_pkg.sv
// Shared opcodes, opcode width and output-buffer state encoding for the bitwise logic unit.
package logic_pkg;

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_AND    = 3'd0;
  localparam logic [OPW-1:0] OP_OR     = 3'd1;
  localparam logic [OPW-1:0] OP_XOR    = 3'd2;
  localparam logic [OPW-1:0] OP_XNOR   = 3'd3;
  localparam logic [OPW-1:0] OP_NAND   = 3'd4;
  localparam logic [OPW-1:0] OP_NOR    = 3'd5;
  localparam logic [OPW-1:0] OP_NOT_A  = 3'd6;
  localparam logic [OPW-1:0] OP_PASS_B = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/logic_alu_comb.sv
// Combinational evaluator: one bitwise operation on two WIDTH-bit operands plus
// zero / all-ones flags derived from the final result.
module logic_alu_comb
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_XNOR:   result = ~(a ^ b);
      OP_NAND:   result = ~(a & b);
      OP_NOR:    result = ~(a | b);
      OP_NOT_A:  result = ~a;
      OP_PASS_B: result = b;
      default:   result = '0;
    endcase
  end

  // For WIDTH=1 these reduce to the inverse and the value of the single bit.
  assign zero = ~(|result);
  assign ones = &result;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit with a 2-entry (main + skid) valid/ready output buffer.
// Defining BITWISE_LOGIC_STATS_EN adds a saturating drain counter on op_count.
module bitwise_logic_unit
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_ones
`ifdef BITWISE_LOGIC_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam int unsigned CNTW = 16;

  buf_state_t       state;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_ones;
  logic [WIDTH-1:0] m_result;
  logic [OPW-1:0]   m_op;
  logic             m_zero;
  logic             m_ones;
  logic             m_valid;
  logic [WIDTH-1:0] s_result;
  logic [OPW-1:0]   s_op;
  logic             s_zero;
  logic             s_ones;
  logic             accept;
  logic             drain;

  logic_alu_comb #(.WIDTH(WIDTH)) u_alu (
    .op    (in_op),
    .a     (in_a),
    .b     (in_b),
    .result(alu_result),
    .zero  (alu_zero),
    .ones  (alu_ones)
  );

  assign accept = in_valid & in_ready;
  assign drain  = m_valid & out_ready;

  // Buffer FSM; in_ready is decoded from the next state so it never depends on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      m_valid  <= 1'b0;
      m_result <= '0;
      m_op     <= '0;
      m_zero   <= 1'b0;
      m_ones   <= 1'b0;
      s_result <= '0;
      s_op     <= '0;
      s_zero   <= 1'b0;
      s_ones   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            m_result <= alu_result;
            m_op     <= in_op;
            m_zero   <= alu_zero;
            m_ones   <= alu_ones;
            m_valid  <= 1'b1;
            state    <= ONE;
          end
        end
        ONE: begin
          in_ready <= 1'b1;
          if (accept && !drain) begin
            s_result <= alu_result;
            s_op     <= in_op;
            s_zero   <= alu_zero;
            s_ones   <= alu_ones;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (accept) begin
            m_result <= alu_result;
            m_op     <= in_op;
            m_zero   <= alu_zero;
            m_ones   <= alu_ones;
          end else if (drain) begin
            m_valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          in_ready <= 1'b0;
          if (drain) begin
            m_result <= s_result;
            m_op     <= s_op;
            m_zero   <= s_zero;
            m_ones   <= s_ones;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b0;
          m_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = m_valid;
  assign out_result = m_result;
  assign out_op     = m_op;
  assign out_zero   = m_zero;
  assign out_ones   = m_ones;

`ifdef BITWISE_LOGIC_STATS_EN
  logic [CNTW-1:0] drain_cnt;

  // Saturating count of delivered beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (drain && (drain_cnt != {CNTW{1'b1}})) begin
      drain_cnt <= drain_cnt + CNTW'(1);
    end
  end

  assign op_count = drain_cnt;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit (WIDTH=4); covers the drain counter
// when BITWISE_LOGIC_STATS_EN is defined.
module tb_bitwise_logic_unit;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         zero;
    logic         ones;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [2:0]   out_op;
  logic         out_zero;
  logic         out_ones;
`ifdef BITWISE_LOGIC_STATS_EN
  logic [15:0]  op_count;
`endif

  logic         rnd_mode;
  logic         rnd_ready;
  logic         man_ready;
  logic         sb_en;
  int           vectors;
  int           miscompares;
  int           drain_model;
  exp_t         q[$];

  // Truth table per opcode, indexed by {a_bit, b_bit}.
  logic [3:0] truth [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001,
                            4'b0111, 4'b0001, 4'b0011, 4'b1010};

  assign out_ready = rnd_mode ? rnd_ready : man_ready;

  bitwise_logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_op    (out_op),
    .out_zero  (out_zero),
    .out_ones  (out_ones)
`ifdef BITWISE_LOGIC_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [3:0] tt;
    tt = truth[op];
    e.op = op;
    for (int i = 0; i < int'(W); i++) e.res[i] = tt[{a[i], b[i]}];
    e.zero = (e.res == '0);
    e.ones = (e.res == {W{1'b1}});
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Offer one beat; returns one time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waits;
    waits = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && waits < 60) begin
      waits++;
      @(negedge clk);
    end
    if (in_ready) q.push_back(model(op, a, b));
    else check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        drain_model = 0;
      end else if (out_valid && out_ready) begin
        if (drain_model != 32'hFFFF) drain_model++;
        if (sb_en) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: actual op=%0d result=%b, required no beat", out_op, out_result);
          end else begin
            e = q.pop_front();
            check("beat", 32'({out_op, out_result, out_zero, out_ones}),
                  32'({e.op, e.res, e.zero, e.ones}));
          end
        end
      end
    end
  endtask

  task automatic rnd_driver();
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    exp_t   b1;
    time    t0;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    vectors = 0;
    miscompares = 0;
    drain_model = 0;
    sb_en = 1'b1;
    rnd_mode = 1'b0;
    rnd_ready = 1'b0;
    man_ready = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    fork
      monitor();
      rnd_driver();
    join_none

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({out_result, out_op, out_zero, out_ones}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // XNOR equal / unequal with one-cycle latency
    man_ready = 1'b1;
    send(3'd3, 4'b1010, 4'b1010);
    @(negedge clk);
    check("latency_xnor_eq", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    send(3'd3, 4'b0111, 4'b1001);
    @(negedge clk);
    check("latency_xnor_ne", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Opcode sweep back to back
    t0 = $time;
    for (int i = 0; i < 8; i++) send(3'(i), 4'b1100, 4'b1010);
    check("sweep_no_gaps", 32'(($time - t0) / 10), 32'd8);
    wait_drain();

    // Backpressure: two beats fill the buffer, third waits
    man_ready = 1'b0;
    b1 = model(3'd2, 4'b0101, 4'b0011);
    send(3'd2, 4'b0101, 4'b0011);
    send(3'd0, 4'b1111, 4'b0110);
    in_valid = 1'b1;
    in_op = 3'd5;
    in_a = 4'b0000;
    in_b = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'({out_valid, out_op, out_result, out_zero, out_ones}),
            32'({1'b1, b1.op, b1.res, b1.zero, b1.ones}));
    end
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    send(3'd5, 4'b0000, 4'b0000);
    wait_drain();

    // Randomized traffic with random backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a = W'($urandom);
      b = W'($urandom);
      send(op, a, b);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_mode = 1'b0;
    man_ready = 1'b1;
    wait_drain();

    // Reset while FULL discards both beats
    man_ready = 1'b0;
    send(3'd1, 4'b0001, 4'b0010);
    send(3'd6, 4'b0011, 4'b0000);
    check("full_before_rst", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    man_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_beat", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

`ifdef BITWISE_LOGIC_STATS_EN
    for (int i = 0; i < 5; i++) send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    wait_drain();
    check("op_count_5", 32'(op_count), 32'd5);
    check("op_count_model", 32'(op_count), 32'(drain_model));
    sb_en = 1'b0;
    in_valid = 1'b1;
    in_op = 3'd2;
    in_a = 4'b1001;
    in_b = 4'b0110;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
    check("op_count_sat", 32'(op_count), 32'h0000FFFF);
    check("op_count_sat_model", 32'(op_count), 32'(drain_model));
    sb_en = 1'b1;
`endif

    send(3'd4, 4'b1111, 4'b1111);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
Parametrised, pipelined successor to the fixed 4-bit XNOR block. It evaluates one of eight bitwise operations on two WIDTH-bit operands. Each result is registered together with zero and all-ones flags and delivered over a valid/ready stream with a 2-entry output buffer. The block sits between an operand source, such as a register file or a test driver, and any consumer that may apply backpressure.

Parameters:
- WIDTH, 4: operand and result width in bits; must be 1 or greater.
- OPW, 3: opcode width in bits; fixed at 3 and not intended for override.

Ports:
- clk, input, 1: single clock, rising-edge active.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: the operand beat is valid.
- in_ready, output, 1: the block can accept a beat this cycle.
- in_op, input, 3: opcode.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- out_valid, output, 1: a result beat is valid.
- out_ready, input, 1: the consumer accepts the beat.
- out_result, output, WIDTH: the bitwise result.
- out_op, output, 3: the opcode that produced out_result.
- out_zero, output, 1: high when out_result is all zeros.
- out_ones, output, 1: high when out_result is all ones. For XNOR this means a equals b.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR.
  - 4 NAND, 5 NOR.
  - 6 NOT_A, computed as the bitwise inverse of a; b is ignored.
  - 7 PASS_B, which outputs b; a is ignored.
- All operations are bitwise over WIDTH bits. The flags are computed from the final WIDTH-bit result.
- Storage: a main register M drives the outputs directly, and a skid register S sits behind it. Each register holds {result, op, zero, ones, valid}.
- FSM states:
  - EMPTY: M and S are both invalid.
  - ONE: M is valid and S is empty.
  - FULL: M and S are both valid.
- in_ready is 1 in EMPTY and ONE, and 0 in FULL. It is a registered, state-decoded signal with no combinational path from out_ready.
- Accept means in_valid and in_ready are both high. Drain means out_valid and out_ready are both high.
- Transitions:
  - EMPTY with accept: load M and go to ONE.
  - ONE, accept without drain: load S and go to FULL.
  - ONE, accept with drain: load M with the new beat and stay in ONE.
  - ONE, drain without accept: go to EMPTY.
  - FULL with drain: M takes S, S is cleared, go to ONE.
  - FULL without drain: hold M and S.
- Latency: an accept in cycle N gives out_valid in cycle N+1 when the buffer was EMPTY, or when it was ONE and drained in the same cycle.
- Throughput: one beat per cycle while out_ready stays high.
- Output stability: while out_valid=1 and out_ready=0, out_result, out_op, out_zero and out_ones hold stable.
- in_op, in_a and in_b are don't-care when in_valid=0.
- Reset: the asynchronous assert immediately clears the state to EMPTY. It forces in_ready=0, out_valid=0, out_result=0, out_op=0, out_zero=0 and out_ones=0. In-flight beats are discarded.
- in_ready rises on the first clk edge after rst deasserts.
- WIDTH=1 boundary: out_zero and out_ones are mutually exclusive inversions of the single result bit.

Optional Feature:
- Macro: BITWISE_LOGIC_STATS_EN.
- When defined: adds output port op_count, 16 bits wide.
  - Increments by 1 on every drain.
  - Saturates at 16'hFFFF.
  - Resets to 0 on rst.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package logic_pkg holds:
  - the opcode localparams OP_AND through OP_PASS_B, values 0 to 7;
  - OPW=3;
  - the buffer state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- Sub-module logic_alu_comb: a purely combinational evaluator taking op, a and b and producing result, zero and ones.
- bitwise_logic_unit instantiates logic_alu_comb once, at the input side, and owns the FSM, both registers and the optional counter.

Test Plan (all with WIDTH=4):
- Basic XNOR, equal operands: rst pulse, then op=3, a=1010, b=1010, out_ready=1. Next cycle: out_valid=1, out_result=1111, out_ones=1, out_zero=0.
- Basic XNOR, unequal operands: op=3, a=0111, b=1001. Expect out_result=0001, out_ones=0, out_zero=0.
- Opcode sweep: a=1100, b=1010 across ops 0 to 7. Expect 1000, 1110, 0110, 1001, 0111, 0001, 0011, 1010 in order, with no gaps when out_ready is held at 1.
- Backpressure: out_ready=0 with three beats offered.
  - Two beats are accepted and in_ready drops to 0 in FULL.
  - The outputs hold beat 1.
  - Raise out_ready: beats 1 and 2 emerge in order, then beat 3 is accepted.
- Reset mid-operation: assert rst in FULL state. Same cycle: out_valid=0 and in_ready=0. After release: EMPTY, with no stale beat delivered.
- BITWISE_LOGIC_STATS_EN: drain 5 beats and expect op_count=5. Preload the counter near saturation via a long run; after 16'hFFFF it stays at 16'hFFFF.
